// File: rtl/sky130_fd_io__gnd_join_seq.sv
`timescale 1ns/1ps
// Ground-domain join sequencer.
// Each channel has its own FSM. A channel waits for its synchronised dom_ok
// to stay high for the debounce window, and then waits for a grant slot.
// After the grant it drives its back-to-back clamp join. Successive grants
// are spaced by GAP_CYC clocks. If a domain drops while joined, the channel
// takes a sticky fault and sits out a hold-off period.
module sky130_fd_io__gnd_join_seq #(
  parameter int unsigned NCH      = 4,
  parameter int unsigned DEB_CYC  = 16,
  parameter int unsigned GAP_CYC  = 8,
  parameter int unsigned HOLD_CYC = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [NCH-1:0] dom_ok,
  input  logic [NCH-1:0] chan_en,
  input  logic           fault_clr,
  output logic [NCH-1:0] join_en,
  output logic [NCH-1:0] fault,
  output logic           joined_all
);

  localparam int unsigned CW = 8;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_DEB    = 3'd1;
  localparam logic [2:0] ST_WAIT   = 3'd2;
  localparam logic [2:0] ST_JOINED = 3'd3;
  localparam logic [2:0] ST_FAULT  = 3'd4;

  logic [NCH-1:0]         sync1_q;
  logic [NCH-1:0]         ok_s_q;
  logic [NCH-1:0][2:0]    st_q, st_d;
  logic [NCH-1:0][CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0]          gap_q, gap_d;
  logic [NCH-1:0]         req, gnt, flt_set;
  logic [NCH-1:0]         join_en_q, fault_q;
  logic                   joined_all_q;
  logic                   all_joined;

  // Two-flop synchroniser for the asynchronous domain-good inputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      ok_s_q  <= '0;
    end else begin
      sync1_q <= dom_ok;
      ok_s_q  <= sync1_q;
    end
  end

  // Slot request: the channel is waiting and its conditions still hold this cycle
  always_comb begin
    req = '0;
    for (int i = 0; i < NCH; i++) begin
      req[i] = (st_q[i] == ST_WAIT) && ok_s_q[i] && chan_en[i];
    end
  end

  // Grant to the lowest requesting index, but only when the gap counter is idle
  always_comb begin
    gnt = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (req[i]) gnt = NCH'(1) << i;
    end
    if (gap_q != '0) gnt = '0;
  end

  // Gap counter: loading GAP_CYC-1 makes the spacing between grants exactly GAP_CYC
  always_comb begin
    gap_d = gap_q;
    if (gnt != '0)          gap_d = CW'(GAP_CYC - 1);
    else if (gap_q != '0)   gap_d = gap_q - CW'(1);
  end

  // Per-channel next state. cnt counts debounce up and hold-off down
  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q;
    flt_set = '0;
    for (int i = 0; i < NCH; i++) begin
      case (st_q[i])
        ST_IDLE: begin
          if (chan_en[i] && ok_s_q[i]) begin
            st_d[i]  = ST_DEB;
            cnt_d[i] = '0;
          end
        end
        ST_DEB: begin
          if (!ok_s_q[i] || !chan_en[i])          st_d[i]  = ST_IDLE;
          else if (cnt_q[i] == CW'(DEB_CYC - 1))  st_d[i]  = ST_WAIT;
          else                                    cnt_d[i] = cnt_q[i] + CW'(1);
        end
        ST_WAIT: begin
          if (!ok_s_q[i] || !chan_en[i]) st_d[i] = ST_IDLE;
          else if (gnt[i])               st_d[i] = ST_JOINED;
        end
        ST_JOINED: begin
          // A domain loss beats an orderly release in the same cycle
          if (!ok_s_q[i]) begin
            st_d[i]    = ST_FAULT;
            cnt_d[i]   = CW'(HOLD_CYC);
            flt_set[i] = 1'b1;
          end else if (!chan_en[i]) begin
            st_d[i] = ST_IDLE;
          end
        end
        ST_FAULT: begin
          if (cnt_q[i] == '0) st_d[i]  = ST_IDLE;
          else                cnt_d[i] = cnt_q[i] - CW'(1);
        end
        default: st_d[i] = ST_IDLE;
      endcase
    end
  end

  // All enabled channels joined; false when nothing is enabled
  always_comb begin
    all_joined = (chan_en != '0);
    for (int i = 0; i < NCH; i++) begin
      if (chan_en[i] && (st_q[i] != ST_JOINED)) all_joined = 1'b0;
    end
  end

  // State, counter and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q         <= '0;
      cnt_q        <= '0;
      gap_q        <= '0;
      join_en_q    <= '0;
      fault_q      <= '0;
      joined_all_q <= 1'b0;
    end else begin
      st_q         <= st_d;
      cnt_q        <= cnt_d;
      gap_q        <= gap_d;
      for (int i = 0; i < NCH; i++) begin
        join_en_q[i] <= (st_q[i] == ST_JOINED);
      end
      fault_q      <= flt_set | (fault_q & ~{NCH{fault_clr}});
      joined_all_q <= all_joined;
    end
  end

  assign join_en    = join_en_q;
  assign fault      = fault_q;
  assign joined_all = joined_all_q;

endmodule
